// File: rtl/lfsr_tick_divider.sv
// Galois-LFSR tick prescaler: one registered pulse each time the LFSR hits the
// programmable terminal value on a qualifying tick; periodic or one-shot.
module lfsr_tick_divider #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAP_MASK     = 8'h1D,
  parameter logic [WIDTH-1:0] SEED         = '1,
  parameter logic [WIDTH-1:0] TERM_DEFAULT = 8'h5A,
  parameter bit               AUTO_START   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick_in,
  input  logic             mode,
  input  logic             start,
  input  logic             load,
  input  logic [WIDTH-1:0] term_val,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lfsr_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lfsr, lfsr_nxt, lfsr_step;
  logic [WIDTH-1:0] term_reg, term_nxt;
  logic             pulse_nxt;
  logic             qual_tick;

  always_comb begin
    lfsr_step[0] = lfsr[WIDTH-1];
    for (int i = 1; i < WIDTH; i++) begin
      lfsr_step[i] = lfsr[i-1] ^ (TAP_MASK[i] & lfsr[WIDTH-1]);
    end
  end

  assign qual_tick = en && tick_in && (state == RUN);

  // load outranks start, start outranks a tick; en only gates the tick path
  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    term_nxt  = term_reg;
    pulse_nxt = 1'b0;
    if (load) begin
      term_nxt = term_val;
      lfsr_nxt = SEED;
      if (start) begin
        state_nxt = RUN;
      end
    end else if (start) begin
      lfsr_nxt  = SEED;
      state_nxt = RUN;
    end else if (qual_tick) begin
      if (lfsr == term_reg) begin
        lfsr_nxt  = SEED;
        pulse_nxt = 1'b1;
        state_nxt = mode ? DONE : RUN;
      end else begin
        lfsr_nxt = lfsr_step;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= AUTO_START ? RUN : IDLE;
      lfsr      <= SEED;
      term_reg  <= TERM_DEFAULT;
      pulse_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      lfsr      <= lfsr_nxt;
      term_reg  <= term_nxt;
      pulse_out <= pulse_nxt;
    end
  end

  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign lfsr_state = lfsr;

endmodule

// File: tb/tb_lfsr_tick_divider.sv
// Directed bench: a 4-bit IDLE-at-reset instance for hand-traced sequences and
// the default 8-bit instance checked against a Galois reference model.
module tb_lfsr_tick_divider;

  logic       clk = 1'b0;
  logic       rst, en, tick_in, mode, start, load;
  logic [3:0] term_val4;
  logic [7:0] term_val8;
  logic       pulse4, busy4, done4;
  logic [3:0] lfsr4;
  logic       pulse8, busy8, done8;
  logic [7:0] lfsr8;
  int         nvec = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  lfsr_tick_divider #(
    .WIDTH(4), .TAP_MASK(4'h3), .SEED(4'hF), .TERM_DEFAULT(4'h1), .AUTO_START(1'b0)
  ) u4 (
    .clk(clk), .rst(rst), .en(en), .tick_in(tick_in), .mode(mode), .start(start),
    .load(load), .term_val(term_val4), .pulse_out(pulse4), .busy(busy4),
    .done(done4), .lfsr_state(lfsr4)
  );

  lfsr_tick_divider u8 (
    .clk(clk), .rst(rst), .en(en), .tick_in(tick_in), .mode(mode), .start(start),
    .load(load), .term_val(term_val8), .pulse_out(pulse8), .busy(busy8),
    .done(done8), .lfsr_state(lfsr8)
  );

  function automatic logic [7:0] step8(input logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
  endfunction

  function automatic int ref_ratio8();
    logic [7:0] s = 8'hFF;
    int n = 0;
    while (s != 8'h5A && n < 256) begin
      s = step8(s);
      n++;
    end
    return n + 1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Ticks the 8-bit instance from SEED until a pulse (bounded), tracking the model.
  task automatic run_to_pulse8(output int k, output int bad);
    logic [7:0] s = 8'hFF;
    bit found = 0;
    k = 0;
    bad = 0;
    tick_in = 1'b1;
    while (!found && k < 300) begin
      cyc();
      k++;
      if (pulse8 === 1'b1) found = 1;
      else begin
        s = step8(s);
        if (lfsr8 !== s) bad++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; tick_in = 1'b0; mode = 1'b0; start = 1'b0; load = 1'b0;
    term_val4 = 4'h0; term_val8 = 8'h00;
    cyc(); cyc();
    rst = 1'b0;
    nvec++; if (lfsr4 !== 4'hF) begin nerr++; $display("FAIL reset_lfsr4: got %h want f", lfsr4); end
    nvec++; if (busy4 !== 1'b0) begin nerr++; $display("FAIL reset_busy4: got %b want 0", busy4); end
    nvec++; if (done4 !== 1'b0 || pulse4 !== 1'b0) begin nerr++; $display("FAIL reset_done_pulse4: got %b%b want 00", done4, pulse4); end
    nvec++; if (lfsr8 !== 8'hFF) begin nerr++; $display("FAIL reset_lfsr8: got %h want ff", lfsr8); end
    nvec++; if (busy8 !== 1'b1) begin nerr++; $display("FAIL reset_busy8: got %b want 1", busy8); end
    nvec++; if (done8 !== 1'b0 || pulse8 !== 1'b0) begin nerr++; $display("FAIL reset_done_pulse8: got %b%b want 00", done8, pulse8); end
  endtask

  task automatic test_idle_ignored();
    tick_in = 1'b1;
    repeat (3) begin
      cyc();
      nvec++; if (lfsr4 !== 4'hF || pulse4 !== 1'b0 || busy4 !== 1'b0) begin
        nerr++; $display("FAIL idle_tick: got lfsr=%h pulse=%b busy=%b want f 0 0", lfsr4, pulse4, busy4);
      end
    end
    tick_in = 1'b0;
  endtask

  task automatic test_periodic();
    logic [3:0] seq [4] = '{4'hD, 4'h9, 4'h1, 4'hF};
    int np = 0;
    load = 1'b1; term_val4 = 4'h1; cyc(); load = 1'b0;
    nvec++; if (busy4 !== 1'b0) begin nerr++; $display("FAIL load_keeps_idle: got busy=%b want 0", busy4); end
    start = 1'b1; cyc(); start = 1'b0;
    nvec++; if (busy4 !== 1'b1 || lfsr4 !== 4'hF) begin nerr++; $display("FAIL start_run: got busy=%b lfsr=%h want 1 f", busy4, lfsr4); end
    tick_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (pulse4 === 1'b1) np++;
      nvec++; if (lfsr4 !== seq[(k-1)%4] || pulse4 !== (k % 4 == 0)) begin
        nerr++; $display("FAIL periodic_t%0d: got lfsr=%h pulse=%b want %h %b", k, lfsr4, pulse4, seq[(k-1)%4], (k % 4 == 0));
      end
    end
    tick_in = 1'b0;
    nvec++; if (np != 3) begin nerr++; $display("FAIL periodic_count: got %0d want 3", np); end
  endtask

  task automatic test_oneshot();
    mode = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    tick_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      nvec++; if (pulse4 !== (k == 4)) begin nerr++; $display("FAIL oneshot_t%0d: got pulse=%b want %b", k, pulse4, (k == 4)); end
    end
    nvec++; if (done4 !== 1'b1 || busy4 !== 1'b0 || lfsr4 !== 4'hF) begin
      nerr++; $display("FAIL oneshot_done: got done=%b busy=%b lfsr=%h want 1 0 f", done4, busy4, lfsr4);
    end
    repeat (4) begin
      cyc();
      nvec++; if (pulse4 !== 1'b0 || lfsr4 !== 4'hF || done4 !== 1'b1) begin
        nerr++; $display("FAIL oneshot_hold: got pulse=%b lfsr=%h done=%b want 0 f 1", pulse4, lfsr4, done4);
      end
    end
    start = 1'b1; cyc(); start = 1'b0;
    nvec++; if (busy4 !== 1'b1 || done4 !== 1'b0 || lfsr4 !== 4'hF || pulse4 !== 1'b0) begin
      nerr++; $display("FAIL oneshot_restart: got busy=%b done=%b lfsr=%h pulse=%b want 1 0 f 0", busy4, done4, lfsr4, pulse4);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      nvec++; if (pulse4 !== (k == 4)) begin nerr++; $display("FAIL oneshot2_t%0d: got pulse=%b want %b", k, pulse4, (k == 4)); end
    end
    tick_in = 1'b0; mode = 1'b0;
  endtask

  task automatic test_term_bounds();
    int np = 0;
    load = 1'b1; start = 1'b1; term_val4 = 4'hF; cyc(); load = 1'b0; start = 1'b0;
    nvec++; if (busy4 !== 1'b1) begin nerr++; $display("FAIL load_start_run: got busy=%b want 1", busy4); end
    tick_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      nvec++; if (pulse4 !== 1'b1 || lfsr4 !== 4'hF) begin
        nerr++; $display("FAIL term_seed_t%0d: got pulse=%b lfsr=%h want 1 f", k, pulse4, lfsr4);
      end
    end
    tick_in = 1'b0;
    load = 1'b1; start = 1'b1; term_val4 = 4'h0; cyc(); load = 1'b0; start = 1'b0;
    tick_in = 1'b1;
    repeat (32) begin
      cyc();
      if (pulse4 !== 1'b0) np++;
    end
    tick_in = 1'b0;
    nvec++; if (np != 0) begin nerr++; $display("FAIL term_zero: got %0d pulses want 0", np); end
  endtask

  task automatic test_load_midcount();
    logic [3:0] seq [4] = '{4'hD, 4'h9, 4'h1, 4'hF};
    load = 1'b1; start = 1'b1; term_val4 = 4'h1; cyc(); load = 1'b0; start = 1'b0;
    tick_in = 1'b1;
    cyc(); cyc();
    nvec++; if (lfsr4 !== 4'h9) begin nerr++; $display("FAIL midcount_pre: got %h want 9", lfsr4); end
    load = 1'b1; cyc(); load = 1'b0;
    nvec++; if (lfsr4 !== 4'hF || pulse4 !== 1'b0) begin
      nerr++; $display("FAIL load_with_tick: got lfsr=%h pulse=%b want f 0", lfsr4, pulse4);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      nvec++; if (lfsr4 !== seq[k-1] || pulse4 !== (k == 4)) begin
        nerr++; $display("FAIL reload_t%0d: got lfsr=%h pulse=%b want %h %b", k, lfsr4, pulse4, seq[k-1], (k == 4));
      end
    end
    tick_in = 1'b0;
  endtask

  task automatic test_enable();
    tick_in = 1'b1;
    cyc(); cyc();
    en = 1'b0;
    repeat (5) begin
      cyc();
      nvec++; if (lfsr4 !== 4'h9 || pulse4 !== 1'b0) begin
        nerr++; $display("FAIL en_hold: got lfsr=%h pulse=%b want 9 0", lfsr4, pulse4);
      end
    end
    en = 1'b1;
    cyc();
    nvec++; if (lfsr4 !== 4'h1 || pulse4 !== 1'b0) begin nerr++; $display("FAIL en_resume1: got lfsr=%h pulse=%b want 1 0", lfsr4, pulse4); end
    cyc();
    nvec++; if (lfsr4 !== 4'hF || pulse4 !== 1'b1) begin nerr++; $display("FAIL en_resume2: got lfsr=%h pulse=%b want f 1", lfsr4, pulse4); end
    cyc();
    en = 1'b0; start = 1'b1; cyc(); start = 1'b0; en = 1'b1;
    nvec++; if (lfsr4 !== 4'hF || busy4 !== 1'b1) begin nerr++; $display("FAIL start_en_low: got lfsr=%h busy=%b want f 1", lfsr4, busy4); end
    tick_in = 1'b0;
  endtask

  task automatic test_divide_w8();
    int exp_ratio = ref_ratio8();
    int k, bad;
    logic [7:0] s = 8'hFF;
    rst = 1'b1; tick_in = 1'b0; mode = 1'b0; cyc(); rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      run_to_pulse8(k, bad);
      nvec++; if (k != exp_ratio || bad != 0 || lfsr8 !== 8'hFF) begin
        nerr++; $display("FAIL ratio8_p%0d: got %0d ticks (%0d lfsr errs, lfsr=%h) want %0d", p, k, bad, lfsr8, exp_ratio);
      end
    end
    for (int i = 0; i < exp_ratio / 2; i++) begin
      cyc();
      s = step8(s);
    end
    nvec++; if (lfsr8 !== s) begin nerr++; $display("FAIL midcount8: got %h want %h", lfsr8, s); end
    #3 rst = 1'b1;
    #1;
    nvec++; if (lfsr8 !== 8'hFF || busy8 !== 1'b1 || pulse8 !== 1'b0 || done8 !== 1'b0) begin
      nerr++; $display("FAIL async_rst8: got lfsr=%h busy=%b pulse=%b done=%b want ff 1 0 0", lfsr8, busy8, pulse8, done8);
    end
    nvec++; if (lfsr4 !== 4'hF || busy4 !== 1'b0) begin
      nerr++; $display("FAIL async_rst4: got lfsr=%h busy=%b want f 0", lfsr4, busy4);
    end
    #1 rst = 1'b0;
    mode = 1'b1;
    run_to_pulse8(k, bad);
    nvec++; if (k != exp_ratio || bad != 0 || done8 !== 1'b1 || busy8 !== 1'b0) begin
      nerr++; $display("FAIL oneshot8: got %0d ticks (%0d errs) done=%b busy=%b want %0d 1 0", k, bad, done8, busy8, exp_ratio);
    end
    #2 rst = 1'b1;
    #1;
    nvec++; if (pulse8 !== 1'b0 || done8 !== 1'b0 || busy8 !== 1'b1 || lfsr8 !== 8'hFF) begin
      nerr++; $display("FAIL async_rst_done8: got pulse=%b done=%b busy=%b lfsr=%h want 0 0 1 ff", pulse8, done8, busy8, lfsr8);
    end
    #1 rst = 1'b0;
    tick_in = 1'b0; mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_ignored();
    test_periodic();
    test_oneshot();
    test_term_bounds();
    test_load_midcount();
    test_enable();
    test_divide_w8();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lfsr_tick_divider.md
Name: lfsr_tick_divider

Overview:
- Parametrised LFSR-based tick prescaler: counts qualifying input ticks with a Galois LFSR and emits a one-cycle output pulse when the LFSR reaches a runtime-programmable terminal value.
- Sits in the LED matrix timing chain between a base tick source (e.g. the millisecond tick) and consumers such as the frame/scroll sequencers.
- Generalises fixed-ratio timers with:
  - width and polynomial parameters;
  - a loadable terminal value;
  - periodic and one-shot modes;
  - start/enable control and status outputs.

Parameters:
- WIDTH, 8, LFSR and terminal-value width (2..16).
- TAP_MASK, 8'h1D, Galois feedback mask, bit i set means next[i] receives XOR with feedback; bit 0 must be 1.
- SEED, all ones, LFSR reload value (must be nonzero).
- TERM_DEFAULT, 8'h5A, terminal value after reset.
- AUTO_START, 1, 1 = enter RUN at reset release; 0 = wait in IDLE for start.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  global enable; 0 freezes LFSR and FSM, ticks ignored
- tick_in  in  1  one-cycle input tick to be divided
- mode  in  1  0 = periodic, 1 = one-shot; sampled at each terminal match
- start  in  1  one-cycle strobe: reload SEED, enter RUN
- load  in  1  one-cycle strobe: capture term_val, reload SEED
- term_val  in  WIDTH  new terminal value, valid with load
- pulse_out  out  1  registered one-cycle divided tick
- busy  out  1  high in RUN
- done  out  1  high in DONE (one-shot finished)
- lfsr_state  out  WIDTH  current LFSR value (debug/readback)

Behaviour:
- LFSR step, Galois form:
  - fb = lfsr[WIDTH-1];
  - next[0] = fb;
  - next[i] = lfsr[i-1] ^ (TAP_MASK[i] & fb) for i ≥ 1.
- Reset (async, any time, including mid-count):
  - lfsr = SEED;
  - term_reg = TERM_DEFAULT;
  - pulse_out = 0; done = 0;
  - state = RUN if AUTO_START else IDLE, so busy = AUTO_START.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start → RUN, lfsr = SEED.
  - RUN + start → stays RUN, lfsr = SEED (restart).
  - RUN + qualifying tick with lfsr == term_reg → pulse; then mode 0 → RUN, mode 1 → DONE.
- Qualifying tick: en=1 and tick_in=1 and state=RUN.
  - If lfsr == term_reg: lfsr = SEED, pulse_out = 1 next cycle.
  - Else: lfsr steps, pulse_out = 0.
- Divide ratio = (steps from SEED to term_reg) + 1 ticks. term_reg == SEED gives a pulse on every tick.
- Latency: pulse_out rises on the clock edge that samples the matching tick; it is high exactly one cycle and is 0 in every cycle without a match.
- Priority, highest first: load > start > tick.
  - load: term_reg = term_val, lfsr = SEED, pulse suppressed that cycle; FSM state unchanged, except that load together with start enters RUN.
  - start with tick: tick ignored.
- en=0: lfsr, term_reg and FSM hold; pulse_out = 0. load and start are still honoured regardless of en.
- A terminal value outside the LFSR sequence (e.g. 0) never matches: no pulse, no error. This is the caller's responsibility.
- tick_in in IDLE/DONE: ignored, lfsr holds.

Test Plan:
- WIDTH=4, TAP_MASK=4'h3, SEED=4'hF, load term_val=4'h1, tick every cycle, mode 0:
  - lfsr_state sequence is F,D,9,1,F…;
  - pulse_out high on every 4th tick;
  - 3 pulses in 12 ticks.
- Same config, mode 1:
  - a single pulse after 4 ticks;
  - then done=1, busy=0, lfsr_state=F, and further ticks give no pulse;
  - start → busy=1 and the next pulse follows 4 ticks later.
- Load term_val=SEED (4'hF): pulse_out on every tick; term_val=4'h0: zero pulses in 32 ticks.
- Assert load after 2 ticks of a count, with tick_in high in the same cycle: lfsr_state=F next cycle, no pulse, and the full period restarts.
- en=0 for 5 cycles with tick_in high mid-count: lfsr_state unchanged and no pulse; resuming en gives a pulse after the remaining ticks only.
- Assert rst asynchronously mid-count, between clock edges: outputs immediately take the reset values (pulse_out=0, done=0, lfsr_state=SEED, busy=AUTO_START). With defaults (WIDTH=8), check the divide ratio against the bit-exact reference model.
